ysyx_23060072_bpu_redirect_ctrl: RTL and testbench
==================================================

YSYX_23060072_BPU_REDIRECT_CTRL -- requirements
Module: ysyx_23060072_bpu_redirect_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, prediction-queue depth (power of 2, >=2).
REQ-002 SHALL have ports: clk_i  in  1  clock; rst_n_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: if_valid_i  in  1  fetch slot issued; if_pc_i  in  32  fetched PC; if_pred_flag_i  in  1  static predictor taken flag; if_pred_pc_i  in  32  static predictor target.
REQ-004 SHALL have port: if_ready_o  out  1  queue can accept a fetch record.
REQ-005 SHALL have ports: ex_valid_i  in  1  instruction resolved in EX, in program order; ex_taken_i  in  1  actual control-flow taken; ex_target_i  in  32  actual target.
REQ-006 SHALL have ports: redirect_valid_o  out  1  redirect request; redirect_pc_o  out  32  correct PC; redirect_ready_i  in  1  IF accepts redirect; flush_o  out  1  one-cycle squash of IF/ID.
REQ-007 SHALL have ports: mispred_cnt_o  out  32  mispredict count; resolve_cnt_o  out  32  resolution count; underflow_o  out  1  sticky: ex_valid_i seen with empty queue.

Function
REQ-008 SHALL hold a QDEPTH-entry FIFO of {pc, pred_flag, pred_pc}; push = if_valid_i & if_ready_o; pop = ex_valid_i & queue non-empty & state RUN.
REQ-009 SHALL drive if_ready_o = (state==RUN) & ~full, from registers only (no combinational path from ex_*).
REQ-010 SHALL allow push and pop in the same cycle; occupancy unchanged; pointers wrap modulo QDEPTH.
REQ-011 SHALL compute on pop: mispredict = (ex_taken_i != head.pred_flag) | (ex_taken_i & (ex_target_i != head.pred_pc)).
REQ-012 SHALL compute correct PC = ex_taken_i ? ex_target_i : head.pc + 4, 32-bit wrap-around addition.
REQ-013 SHALL implement FSM with states RUN, REDIR; reset state RUN.
REQ-014 SHALL on pop with mispredict in RUN: next cycle state REDIR, redirect_valid_o=1, redirect_pc_o=correct PC (registered), flush_o=1 for exactly that first cycle, queue emptied.
REQ-015 SHALL discard a push occurring in the same cycle as a mispredicting pop (wrong-path fetch).
REQ-016 SHALL hold redirect_valid_o and redirect_pc_o stable in REDIR until redirect_ready_i=1; on that cycle return to RUN next cycle.
REQ-017 SHALL ignore ex_valid_i and block pushes while in REDIR (no pop, no counting).
REQ-018 SHALL increment resolve_cnt_o on every pop and mispred_cnt_o on every mispredicting pop; both saturate at 32'hFFFF_FFFF.
REQ-019 SHALL set underflow_o when ex_valid_i=1 in RUN with empty queue; no pop, no count; clears only on reset.
REQ-020 SHALL have latency: pop cycle N -> redirect_valid_o/flush_o asserted cycle N+1.

Reset
REQ-021 SHALL on rst_n_i=0 asynchronously set: state RUN, queue empty, pointers 0, if_ready_o=1 after reset release, redirect_valid_o=0, redirect_pc_o=0, flush_o=0, counters 0, underflow_o=0.
REQ-022 SHALL abandon any pending redirect when reset asserts mid-REDIR; no redirect after release.

Structure
REQ-023 SHALL take FSM state encoding and the instruction-length constant (4) from the shared ysyx_23060072 define/package file.
REQ-024 SHALL instantiate one sub-module ysyx_23060072_pred_fifo (parameterised FIFO with full/empty, clear, simultaneous push/pop); FSM and counters stay in the top.

Verification
REQ-025 SHALL cover: push pc=0x8000_0000 flag=1 target=0x8000_0010; resolve taken, target 0x8000_0010 -> no redirect, resolve_cnt=1, mispred_cnt=0.
REQ-026 SHALL cover: push pc=0x8000_0020 flag=1; resolve not-taken -> next cycle redirect_valid_o=1, redirect_pc_o=0x8000_0024, flush_o=1 for one cycle, mispred_cnt=1.
REQ-027 SHALL cover: push flag=0 pc=0x8000_0040; resolve taken target 0x8000_0100 with redirect_ready_i=0 for 3 cycles -> redirect held 4 cycles, pc 0x8000_0100, if_ready_o=0, ex_valid_i ignored during hold.
REQ-028 SHALL cover: 4 pushes without pop -> if_ready_o=0; same-cycle push+pop when 3 entries -> occupancy stays 3; pc=0xFFFF_FFFC not-taken mispredict -> redirect_pc_o=0x0000_0000.
REQ-029 SHALL cover: ex_valid_i with empty queue -> underflow_o=1 sticky, counters unchanged; rst_n_i low mid-REDIR -> all outputs reset values immediately.

Source files
------------

// File: rtl/ysyx_23060072_bpu_redirect_ctrl_pkg.sv
// Shared definitions for the BPU redirect controller: FSM encoding,
// instruction length, prediction record layout and small helpers.
package ysyx_23060072_bpu_redirect_ctrl_pkg;

  // Fixed instruction length used to form the fall-through PC.
  localparam logic [31:0] INST_LEN = 32'd4;

  // Saturation ceiling for the statistics counters.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Controller states: normal operation, or waiting for IF to take a redirect.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } redir_state_e;

  // One fetch record kept until the instruction resolves in EX.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_flag;
    logic [31:0] pred_pc;
  } pred_entry_t;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

  // A prediction is wrong if the direction differs, or if both say taken
  // but the targets differ.
  function automatic logic is_mispredict(input pred_entry_t e,
                                         input logic        taken,
                                         input logic [31:0] target);
    return (taken != e.pred_flag) | (taken & (target != e.pred_pc));
  endfunction

  // Architecturally correct next PC once the outcome is known.
  function automatic logic [31:0] correct_pc(input pred_entry_t e,
                                             input logic        taken,
                                             input logic [31:0] target);
    logic [31:0] r;
    if (taken) begin
      r = target;
    end else begin
      r = e.pc + INST_LEN;
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060072_pred_fifo.sv
// Prediction FIFO: holds in-flight fetch records in program order.
// Supports simultaneous push/pop and a synchronous clear that wins over both.
module ysyx_23060072_pred_fifo
  import ysyx_23060072_bpu_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  pred_entry_t data_i,
  input  logic        pop_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  pred_entry_t mem_q [DEPTH];

  logic full_s, empty_s, push_ok_s, pop_ok_s;

  assign empty_s   = (wptr_q == rptr_q);
  assign full_s    = (wptr_q[AW] != rptr_q[AW]) & (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok_s = push_i & ~full_s;
  assign pop_ok_s  = pop_i & ~empty_s;

  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Next pointer values; clear returns the queue to empty.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_ok_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; a push that coincides with clear is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s & ~clear_i) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ysyx_23060072_bpu_redirect_ctrl.sv
// BPU redirect controller: queues static predictions from IF, checks them
// against EX resolutions, and issues a registered redirect + one-cycle flush
// on a mispredict. Also keeps resolve/mispredict statistics.
module ysyx_23060072_bpu_redirect_ctrl
  import ysyx_23060072_bpu_redirect_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic        if_pred_flag_i,
  input  logic [31:0] if_pred_pc_i,
  output logic        if_ready_o,
  input  logic        ex_valid_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        flush_o,
  output logic [31:0] mispred_cnt_o,
  output logic [31:0] resolve_cnt_o,
  output logic        underflow_o
);

  redir_state_e state_q, state_d;
  logic         redir_valid_q, redir_valid_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         flush_q, flush_d;
  logic [31:0]  mispred_cnt_q, mispred_cnt_d;
  logic [31:0]  resolve_cnt_q, resolve_cnt_d;
  logic         underflow_q, underflow_d;

  pred_entry_t  head_s, push_data_s;
  logic         full_s, empty_s;
  logic         in_run_s, push_s, pop_s, mispred_s, fifo_push_s;

  // if_ready depends only on registered state and FIFO pointers.
  assign in_run_s   = (state_q == ST_RUN);
  assign if_ready_o = in_run_s & ~full_s;

  assign push_s    = if_valid_i & if_ready_o;
  assign pop_s     = ex_valid_i & ~empty_s & in_run_s;
  assign mispred_s = pop_s & is_mispredict(head_s, ex_taken_i, ex_target_i);

  // A fetch arriving with a mispredicting resolution is wrong-path.
  assign fifo_push_s = push_s & ~mispred_s;

  assign push_data_s.pc        = if_pc_i;
  assign push_data_s.pred_flag = if_pred_flag_i;
  assign push_data_s.pred_pc   = if_pred_pc_i;

  ysyx_23060072_pred_fifo #(
    .DEPTH (QDEPTH)
  ) u_pred_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (mispred_s),
    .push_i  (fifo_push_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // FSM next state and redirect/flush outputs.
  always_comb begin
    state_d       = state_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mispred_s) begin
          state_d       = ST_REDIR;
          redir_valid_d = 1'b1;
          redir_pc_d    = correct_pc(head_s, ex_taken_i, ex_target_i);
          flush_d       = 1'b1;
        end else begin
          state_d       = ST_RUN;
          redir_valid_d = 1'b0;
        end
      end
      ST_REDIR: begin
        if (redirect_ready_i) begin
          state_d       = ST_RUN;
          redir_valid_d = 1'b0;
        end else begin
          state_d       = ST_REDIR;
          redir_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_RUN;
        redir_valid_d = 1'b0;
      end
    endcase
  end

  // Statistics and sticky underflow flag.
  always_comb begin
    resolve_cnt_d = resolve_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    underflow_d   = underflow_q;
    if (pop_s) begin
      resolve_cnt_d = sat_inc(resolve_cnt_q);
    end else begin
      resolve_cnt_d = resolve_cnt_q;
    end
    if (mispred_s) begin
      mispred_cnt_d = sat_inc(mispred_cnt_q);
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
    if (ex_valid_i & in_run_s & empty_s) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State, redirect and statistics registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_RUN;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      flush_q       <= 1'b0;
      mispred_cnt_q <= 32'd0;
      resolve_cnt_q <= 32'd0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
      mispred_cnt_q <= mispred_cnt_d;
      resolve_cnt_q <= resolve_cnt_d;
      underflow_q   <= underflow_d;
    end
  end

  assign redirect_valid_o = redir_valid_q;
  assign redirect_pc_o    = redir_pc_q;
  assign flush_o          = flush_q;
  assign mispred_cnt_o    = mispred_cnt_q;
  assign resolve_cnt_o    = resolve_cnt_q;
  assign underflow_o      = underflow_q;

endmodule

// File: tb/tb_ysyx_23060072_bpu_redirect_ctrl.sv
// Self-checking bench for the BPU redirect controller: directed scenarios
// followed by random traffic, all checked against a queue-based model.
module tb_ysyx_23060072_bpu_redirect_ctrl;

  localparam int QDEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic        if_pred_flag_i;
  logic [31:0] if_pred_pc_i;
  logic        if_ready_o;
  logic        ex_valid_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        flush_o;
  logic [31:0] mispred_cnt_o;
  logic [31:0] resolve_cnt_o;
  logic        underflow_o;

  ysyx_23060072_bpu_redirect_ctrl #(.QDEPTH(QDEPTH)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .if_valid_i       (if_valid_i),
    .if_pc_i          (if_pc_i),
    .if_pred_flag_i   (if_pred_flag_i),
    .if_pred_pc_i     (if_pred_pc_i),
    .if_ready_o       (if_ready_o),
    .ex_valid_i       (ex_valid_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .flush_o          (flush_o),
    .mispred_cnt_o    (mispred_cnt_o),
    .resolve_cnt_o    (resolve_cnt_o),
    .underflow_o      (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain queue of outstanding predictions plus flags.
  typedef struct {
    logic [31:0] pc;
    bit          flag;
    logic [31:0] ppc;
  } ent_t;

  ent_t        mq[$];
  bit          m_redir;
  bit          m_rvalid;
  logic [31:0] m_rpc;
  bit          m_flush;
  logic [31:0] m_mcnt;
  logic [31:0] m_rcnt;
  bit          m_uflow;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_redir  = 1'b0;
    m_rvalid = 1'b0;
    m_rpc    = 32'd0;
    m_flush  = 1'b0;
    m_mcnt   = 32'd0;
    m_rcnt   = 32'd0;
    m_uflow  = 1'b0;
  endtask

  function automatic bit m_ready();
    return !m_redir && (mq.size() < QDEPTH);
  endfunction

  task automatic model_step(input bit iv, input logic [31:0] ipc, input bit iflag,
                            input logic [31:0] ippc, input bit ev, input bit et,
                            input logic [31:0] etgt, input bit rr);
    bit   ready;
    bit   mis;
    ent_t h;
    ent_t n;
    ready   = m_ready();
    mis     = 1'b0;
    m_flush = 1'b0;
    if (m_redir) begin
      if (rr) begin
        m_redir  = 1'b0;
        m_rvalid = 1'b0;
      end
    end else begin
      if (ev) begin
        if (mq.size() == 0) begin
          m_uflow = 1'b1;
        end else begin
          h      = mq.pop_front();
          m_rcnt = sat(m_rcnt);
          mis    = (et != h.flag) || (et && (etgt != h.ppc));
          if (mis) begin
            m_mcnt   = sat(m_mcnt);
            m_rpc    = et ? etgt : h.pc + 32'd4;
            m_rvalid = 1'b1;
            m_redir  = 1'b1;
            m_flush  = 1'b1;
            mq.delete();
          end
        end
      end
      if (iv && ready && !mis) begin
        n.pc   = ipc;
        n.flag = iflag;
        n.ppc  = ippc;
        mq.push_back(n);
      end
    end
  endtask

  task automatic check_outputs();
    chk("if_ready",       32'(if_ready_o),       32'(m_ready()));
    chk("redirect_valid", 32'(redirect_valid_o), 32'(m_rvalid));
    chk("redirect_pc",    redirect_pc_o,         m_rpc);
    chk("flush",          32'(flush_o),          32'(m_flush));
    chk("mispred_cnt",    mispred_cnt_o,         m_mcnt);
    chk("resolve_cnt",    resolve_cnt_o,         m_rcnt);
    chk("underflow",      32'(underflow_o),      32'(m_uflow));
  endtask

  // Apply one cycle of inputs (called at a negedge), then check after the edge.
  task automatic step(input bit iv, input logic [31:0] ipc, input bit iflag,
                      input logic [31:0] ippc, input bit ev, input bit et,
                      input logic [31:0] etgt, input bit rr);
    if_valid_i       = iv;
    if_pc_i          = ipc;
    if_pred_flag_i   = iflag;
    if_pred_pc_i     = ippc;
    ex_valid_i       = ev;
    ex_taken_i       = et;
    ex_target_i      = etgt;
    redirect_ready_i = rr;
    model_step(iv, ipc, iflag, ippc, ev, et, etgt, rr);
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input bit flag, input logic [31:0] ppc);
    step(1'b1, pc, flag, ppc, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Resolve the oldest entry exactly as predicted (never mispredicts).
  task automatic pop_ok(input bit iv, input logic [31:0] ipc);
    step(iv, ipc, 1'b0, 32'd0, 1'b1, mq[0].flag, mq[0].ppc, 1'b0);
  endtask

  task automatic clear_inputs();
    if_valid_i       = 1'b0;
    if_pc_i          = 32'd0;
    if_pred_flag_i   = 1'b0;
    if_pred_pc_i     = 32'd0;
    ex_valid_i       = 1'b0;
    ex_taken_i       = 1'b0;
    ex_target_i      = 32'd0;
    redirect_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          iv, fl, ev, et, rr;
    logic [31:0] pc, ppc, tgt;

    rst_n_i = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check_outputs();

    // Correct taken prediction: no redirect, one resolution.
    push(32'h8000_0000, 1'b1, 32'h8000_0010);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0010, 1'b0);
    chk("c1_resolve", resolve_cnt_o, 32'd1);
    chk("c1_mispred", mispred_cnt_o, 32'd0);
    chk("c1_novalid", 32'(redirect_valid_o), 32'd0);

    // Predicted taken, actually not taken: redirect to pc+4, one-cycle flush.
    push(32'h8000_0020, 1'b1, 32'h8000_0030);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("c2_valid",   32'(redirect_valid_o), 32'd1);
    chk("c2_pc",      redirect_pc_o, 32'h8000_0024);
    chk("c2_flush",   32'(flush_o), 32'd1);
    chk("c2_mispred", mispred_cnt_o, 32'd1);
    idle();
    chk("c2_flush_1cyc", 32'(flush_o), 32'd0);
    chk("c2_hold",       32'(redirect_valid_o), 32'd1);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("c2_released",   32'(redirect_valid_o), 32'd0);

    // Predicted not taken, actually taken; IF stalls the redirect 3 cycles.
    push(32'h8000_0040, 1'b0, 32'd0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h8000_0200, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
      chk("c3_hold_valid", 32'(redirect_valid_o), 32'd1);
      chk("c3_hold_pc",    redirect_pc_o, 32'h8000_0100);
      chk("c3_if_ready",   32'(if_ready_o), 32'd0);
    end
    chk("c3_resolve_frozen", resolve_cnt_o, 32'd3);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("c3_released", 32'(redirect_valid_o), 32'd0);

    // Fill to capacity, then simultaneous push/pop at three entries.
    for (int i = 0; i < 4; i++) push(32'h9000_0000 + 32'(i * 4), 1'b0, 32'd0);
    chk("c4_full", 32'(if_ready_o), 32'd0);
    pop_ok(1'b0, 32'd0);
    pop_ok(1'b1, 32'h9000_0100);
    chk("c4_three_ready", 32'(if_ready_o), 32'd1);
    push(32'h9000_0104, 1'b0, 32'd0);
    chk("c4_full_again", 32'(if_ready_o), 32'd0);
    while (mq.size() > 0) pop_ok(1'b0, 32'd0);

    // Fall-through wrap-around at the top of the address space.
    push(32'hFFFF_FFFC, 1'b1, 32'h0000_1000);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("c4_wrap_pc", redirect_pc_o, 32'h0000_0000);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Resolution with nothing queued: sticky underflow, counters untouched.
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h4, 1'b0);
    chk("c5_underflow", 32'(underflow_o), 32'd1);
    idle();
    chk("c5_sticky", 32'(underflow_o), 32'd1);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      iv  = ($urandom_range(0, 99) < 60);
      pc  = $urandom() & 32'hFFFF_FFFC;
      fl  = $urandom_range(0, 1) == 1;
      ppc = pc + 32'($urandom_range(0, 3) * 4);
      ev  = ($urandom_range(0, 99) < 45);
      rr  = ($urandom_range(0, 99) < 50);
      et  = $urandom_range(0, 1) == 1;
      tgt = $urandom() & 32'hFFFF_FFFC;
      if (mq.size() > 0 && $urandom_range(0, 99) < 75) begin
        et  = mq[0].flag;
        tgt = mq[0].ppc;
      end
      step(iv, pc, fl, ppc, ev, et, tgt, rr);
    end

    // Reset asserted while a redirect is pending.
    while (m_redir) idle();
    push(32'hA000_0000, 1'b1, 32'hA000_0040);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("c6_in_redir", 32'(redirect_valid_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    chk("c6_rst_valid",   32'(redirect_valid_o), 32'd0);
    chk("c6_rst_pc",      redirect_pc_o, 32'd0);
    chk("c6_rst_flush",   32'(flush_o), 32'd0);
    chk("c6_rst_mcnt",    mispred_cnt_o, 32'd0);
    chk("c6_rst_rcnt",    resolve_cnt_o, 32'd0);
    chk("c6_rst_uflow",   32'(underflow_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check_outputs();
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("c6_no_redirect", 32'(redirect_valid_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
